// File: rtl/mram_port_arb.sv
// Two-requester round-robin arbiter for a single MRAM macro port.
// One operation in flight; read latency is fixed, write completion waits on M_WRC with a timeout.
module mram_port_arb #(
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned WR_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic [1:0]  REQ,
    input  logic [1:0]  REQ_WE,
    input  logic [33:0] REQ_A,
    input  logic [63:0] REQ_DIN,
    input  logic [7:0]  REQ_BEN,
    output logic [1:0]  GNT,
    output logic [1:0]  RSP_VLD,
    output logic [31:0] RSP_DATA,
    output logic        RSP_UE,
    output logic        RSP_TO,
    output logic        M_CEb,
    output logic        M_WEb,
    output logic [16:0] M_A,
    output logic [31:0] M_DIN,
    output logic [3:0]  M_BEN,
    input  logic [31:0] M_DOUT,
    input  logic [3:0]  M_UE,
    input  logic        M_WRC,
    output logic        BUSY
);

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned CW = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_WAIT = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          win_q, win_d;
    logic          we_q, we_d;
    logic          pick;

    logic [1:0]    gnt_d, vld_d;
    logic          ceb_d, web_d, ue_d, to_d, busy_d;
    logic [AW-1:0] a_d;
    logic [DW-1:0] din_d, data_d;
    logic [BW-1:0] ben_d;

    // On contention the requester not most recently granted wins; otherwise the sole requester.
    assign pick = (REQ == 2'b11) ? ~last_q : REQ[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        win_d   = win_q;
        we_d    = we_q;
        gnt_d   = 2'b00;
        vld_d   = 2'b00;
        ceb_d   = 1'b1;
        web_d   = 1'b1;
        a_d     = M_A;
        din_d   = M_DIN;
        ben_d   = M_BEN;
        data_d  = RSP_DATA;
        ue_d    = RSP_UE;
        to_d    = RSP_TO;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (|REQ) begin
                    state_d = S_CMD;
                    win_d   = pick;
                    last_d  = pick;
                    we_d    = REQ_WE[pick];
                    gnt_d   = {pick, ~pick};
                    ceb_d   = 1'b0;
                    web_d   = ~REQ_WE[pick];
                    a_d     = pick ? REQ_A[2*AW-1:AW]     : REQ_A[AW-1:0];
                    din_d   = pick ? REQ_DIN[2*DW-1:DW]   : REQ_DIN[DW-1:0];
                    ben_d   = pick ? REQ_BEN[2*BW-1:BW]   : REQ_BEN[BW-1:0];
                end
            end
            S_CMD: begin
                // cnt tracks cycles elapsed since the command cycle
                cnt_d   = CW'(1);
                state_d = we_q ? S_WR_WAIT : S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (cnt_q == CW'(RD_LAT)) begin
                    state_d = S_RESP;
                    vld_d   = {win_q, ~win_q};
                    data_d  = M_DOUT;
                    ue_d    = |M_UE;
                    to_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WR_WAIT: begin
                // completion on the final allowed cycle still counts as success
                if (M_WRC || (cnt_q == CW'(WR_TIMEOUT))) begin
                    state_d = S_RESP;
                    vld_d   = {win_q, ~win_q};
                    ue_d    = 1'b0;
                    to_d    = ~M_WRC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            GNT      <= 2'b00;
            RSP_VLD  <= 2'b00;
            RSP_DATA <= '0;
            RSP_UE   <= 1'b0;
            RSP_TO   <= 1'b0;
            M_CEb    <= 1'b1;
            M_WEb    <= 1'b1;
            M_A      <= '0;
            M_DIN    <= '0;
            M_BEN    <= '0;
            BUSY     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            win_q    <= win_d;
            we_q     <= we_d;
            GNT      <= gnt_d;
            RSP_VLD  <= vld_d;
            RSP_DATA <= data_d;
            RSP_UE   <= ue_d;
            RSP_TO   <= to_d;
            M_CEb    <= ceb_d;
            M_WEb    <= web_d;
            M_A      <= a_d;
            M_DIN    <= din_d;
            M_BEN    <= ben_d;
            BUSY     <= busy_d;
        end
    end

endmodule

// File: doc/mram_port_arb.md
MRAM_PORT_ARB -- requirements
Module: mram_port_arb

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 2: cycles from the macro command cycle to valid M_DOUT (legal range 1-7).
REQ-002 The block SHALL have parameter WR_TIMEOUT, default 255: maximum cycles to wait for M_WRC after a write command (legal range 2-255).
REQ-003 The block SHALL have a single clock and a synchronous, active-low reset.
REQ-004 CLK  in  1  single clock, rising edge.
REQ-005 RSTb  in  1  reset, synchronous, active-low.
REQ-006 REQ  in  2  per-requester request; bit 0 = host, bit 1 = scrub.
REQ-007 REQ_WE  in  2  per-requester op: 1 = write, 0 = read.
REQ-008 REQ_A  in  34  packed addresses {r1[16:0], r0[16:0]}.
REQ-009 REQ_DIN  in  64  packed write data {r1[31:0], r0[31:0]}.
REQ-010 REQ_BEN  in  8  packed byte enables {r1[3:0], r0[3:0]}.
REQ-011 GNT  out  2  one-hot, one-cycle accept pulse.
REQ-012 RSP_VLD  out  2  one-hot, one-cycle completion pulse.
REQ-013 RSP_DATA  out  32  read data; RSP_UE  out  1  uncorrectable-error flag; RSP_TO  out  1  write-timeout flag.
REQ-014 M_CEb, M_WEb  out  1 each  macro chip enable and write enable, both active-low.
REQ-015 M_A  out  17; M_DIN  out  32; M_BEN  out  4  macro command fields.
REQ-016 M_DOUT  in  32; M_UE  in  4; M_WRC  in  1  macro read data, per-byte UE, write-complete.
REQ-017 BUSY  out  1  operation in flight.

Function
REQ-018 FSM states SHALL be IDLE, CMD, RD_WAIT, WR_WAIT and RESP; exactly one operation SHALL be in flight at a time.
REQ-019 IDLE: with no REQ bit set, the FSM SHALL remain in IDLE.
REQ-020 IDLE: with any REQ bit set, the FSM SHALL select a winner by round-robin and move to CMD.
REQ-021 Round-robin: on contention the winner SHALL be the requester not most recently granted; the pointer SHALL update only on grant.
REQ-022 Round-robin: after reset, requester 0 SHALL win the first contention.
REQ-023 CMD (one cycle): GNT[winner]=1, M_CEb=0, and M_WEb = ~REQ_WE[winner].
REQ-024 CMD: M_A, M_DIN and M_BEN SHALL carry the winner's fields, captured from the IDLE-cycle inputs.
REQ-025 Requesters SHALL hold REQ and all fields stable until GNT; GNT is therefore REQ-sample cycle + 1.
REQ-026 Outside CMD, M_CEb and M_WEb SHALL be 1, and M_A, M_DIN and M_BEN SHALL hold their last values.
REQ-027 Read: RD_WAIT SHALL count RD_LAT cycles from the CMD cycle c, then sample M_DOUT and |M_UE at cycle c+RD_LAT.
REQ-028 Read: in RESP (cycle c+RD_LAT+1), RSP_VLD[winner]=1, RSP_DATA = sampled data, RSP_UE = sampled OR, RSP_TO=0.
REQ-029 Write: WR_WAIT SHALL monitor M_WRC from cycle c+1; M_WRC in the CMD cycle SHALL be ignored.
REQ-030 Write: M_WRC=1 at cycle w SHALL give RESP at w+1 with RSP_TO=0, RSP_UE=0 and RSP_DATA unchanged.
REQ-031 Write: if M_WRC is still 0 at cycle c+WR_TIMEOUT, RESP SHALL follow with RSP_TO=1.
REQ-032 Write: M_WRC=1 exactly at cycle c+WR_TIMEOUT SHALL count as success (RSP_TO=0).
REQ-033 RESP SHALL last one cycle and return to IDLE; the next GNT is therefore no earlier than RESP + 2.
REQ-034 REQ changes during CMD, RD_WAIT, WR_WAIT or RESP SHALL be ignored.
REQ-035 RSP_DATA, RSP_UE and RSP_TO SHALL hold their values until the next RESP.
REQ-036 BUSY SHALL be 1 in CMD, RD_WAIT, WR_WAIT and RESP, and 0 in IDLE.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 RSTb=0 at a rising edge SHALL force state IDLE, round-robin pointer to favour requester 0, and wait counter to 0.
REQ-039 Reset output values: M_CEb=1, M_WEb=1, M_A=0, M_DIN=0, M_BEN=0, GNT=0, RSP_VLD=0, RSP_DATA=0, RSP_UE=0, RSP_TO=0, BUSY=0.
REQ-040 Reset during any non-IDLE state SHALL abandon the operation with no RSP_VLD; the first post-reset REQ SHALL be served normally.

Verification
REQ-041 Host read: REQ=01, WE=0, A0=0x00010, M_DOUT=0xDEADBEEF at c+2 -> GNT=01 at t+1, M_CEb=0, M_WEb=1 in the same cycle, RSP_VLD=01 at c+3, RSP_DATA=0xDEADBEEF, RSP_UE=0.
REQ-042 Contention: REQ=11 held continuously -> GNT sequence 01, 10, 01; RSP_VLD follows the same order.
REQ-043 Write: r1 write of A=0x1FFFF, DIN=0x12345678, BEN=0xF, M_WRC pulse at c+5 -> M_A=0x1FFFF, M_DIN=0x12345678 at CMD, RSP_VLD=10 at c+6, RSP_TO=0.
REQ-044 Timeout: write with M_WRC held 0, WR_TIMEOUT=8 -> RSP_VLD at c+9 with RSP_TO=1; a second run with M_WRC=1 at c+8 -> RSP_TO=0.
REQ-045 UE plus reset: read with M_UE=4'b0100 -> RSP_UE=1; RSTb=0 asserted in RD_WAIT -> no RSP_VLD, BUSY=0 and M_CEb=1 the next cycle.
